// File: rtl/calc_pkg.sv
// Calculator shared definitions: 5-bit keycodes, the keypad scanner
// FSM state type, and the key-index to keycode lookup used by both
// keypad_scanner and the calculator core.
package calc_pkg;

    localparam int KEY_W = 5;

    // Function keycodes (digit keys are {1'b1, hex value})
    localparam logic [KEY_W-1:0] KEY_SQR     = 5'b00001;
    localparam logic [KEY_W-1:0] KEY_CH_SIGN = 5'b00010;
    localparam logic [KEY_W-1:0] KEY_EQUALS  = 5'b00011;
    localparam logic [KEY_W-1:0] KEY_CA      = 5'b00100;
    localparam logic [KEY_W-1:0] KEY_MULTI   = 5'b01001;
    localparam logic [KEY_W-1:0] KEY_SUB     = 5'b01010;
    localparam logic [KEY_W-1:0] KEY_ADD     = 5'b01011;
    localparam logic [KEY_W-1:0] KEY_CE      = 5'b01100;

    // Matrix position with no key legend; scanned but never reported
    localparam logic [4:0] IDX_UNUSED = 5'd24;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_e;

    // Matrix index (col*5 + row) to calculator keycode
    function automatic logic [KEY_W-1:0] index_to_keycode(input logic [4:0] idx);
        logic [KEY_W-1:0] code;
        code = 5'b00000;
        if (idx < 5'd16) begin
            code = {1'b1, idx[3:0]};
        end else begin
            case (idx)
                5'd16:   code = KEY_SQR;
                5'd17:   code = KEY_CH_SIGN;
                5'd18:   code = KEY_EQUALS;
                5'd19:   code = KEY_CA;
                5'd20:   code = KEY_MULTI;
                5'd21:   code = KEY_SUB;
                5'd22:   code = KEY_ADD;
                5'd23:   code = KEY_CE;
                default: code = 5'b00000;
            endcase
        end
        return code;
    endfunction

    // True when exactly one active-low row line is asserted
    function automatic logic single_low(input logic [4:0] row_n);
        return $countones(~row_n) == 1;
    endfunction

    // Position of the (lowest) asserted active-low row line
    function automatic logic [2:0] low_row(input logic [4:0] row_n);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!row_n[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pad inputs.
// Resets to all-ones, the idle level of pulled-up active-low pads.
module key_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the pad value into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: reset to the idle (released) level so no phantom key press follows reset
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            // NOTE: non-blocking so both stages update from pre-edge values, giving a true 2-flop chain
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 5x5 keypad scanner: drives one column at a time, debounces a single
// pressed key and emits its calculator keycode with a one-cycle newkey.
// Optional macro KEYPAD_REPEAT_EN enables auto-repeat of held digit keys.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20,
    parameter int CNT_W         = 16
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 50_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] col_n,
    input  logic [4:0] row_n,
    output logic [4:0] keycode,
    output logic       newkey,
    output logic       key_held
);

    logic [4:0]       w_row_sync;
    logic             w_tick;
    logic             w_single;
    logic [2:0]       w_row_idx;
    logic [4:0]       w_index;
    logic [4:0]       w_held_pat;
    logic             w_same;
    logic             w_all_high;
    logic             w_db_last;
    logic [CNT_W-1:0] w_db_inc;
    logic [2:0]       w_col_next;
    logic             w_rep_fire;

    logic [CNT_W-1:0] r_div_cnt;
    kp_state_e        r_state;
    logic [2:0]       r_col;
    logic [4:0]       r_col_n;
    logic [2:0]       r_row;
    logic [4:0]       r_index;
    logic [CNT_W-1:0] r_db_cnt;
    logic [4:0]       r_keycode;
    logic             r_newkey;
    logic             r_key_held;

    key_sync #(.WIDTH(5)) u_row_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (row_n),
        .o_sync  (w_row_sync)
    );

    // Sample point: last cycle of each column period
    assign w_tick     = (r_div_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_single   = single_low(w_row_sync);
    assign w_row_idx  = low_row(w_row_sync);
    assign w_index    = ({2'b00, r_col} * 5'd5) + {2'b00, w_row_idx};
    assign w_held_pat = ~(5'b00001 << r_row);
    assign w_same     = (w_row_sync == w_held_pat);
    assign w_all_high = &w_row_sync;
    assign w_db_last  = (r_db_cnt >= CNT_W'(DEBOUNCE_CNT - 1));
    assign w_db_inc   = (r_db_cnt == '1) ? r_db_cnt : r_db_cnt + 1'b1;
    assign w_col_next = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] r_rep_cnt;

    assign w_rep_fire = (r_state == ST_HELD) && r_keycode[4] &&
                        (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

    // Hold-time counter for digit auto-repeat; restarts on each pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (r_state != ST_HELD || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt != '1) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Column period divider, free-running in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Scan / debounce FSM with registered column drive and key outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SCAN;
            r_col      <= 3'd0;
            r_col_n    <= 5'b11110;
            r_row      <= 3'd0;
            r_index    <= 5'd0;
            r_db_cnt   <= '0;
            r_keycode  <= 5'b00000;
            r_newkey   <= 1'b0;
            r_key_held <= 1'b0;
        end else begin
            r_newkey <= w_rep_fire;
            case (r_state)
                ST_SCAN: begin
                    if (w_tick) begin
                        if (w_single) begin
                            r_index  <= w_index;
                            r_row    <= w_row_idx;
                            r_db_cnt <= '0;
                            r_state  <= ST_PRESS_DB;
                        end else begin
                            r_col   <= w_col_next;
                            r_col_n <= {r_col_n[3:0], r_col_n[4]};
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (w_tick) begin
                        if (w_same) begin
                            if (w_db_last) begin
                                r_db_cnt   <= '0;
                                r_key_held <= 1'b1;
                                r_state    <= ST_HELD;
                                if (r_index != IDX_UNUSED) begin
                                    r_keycode <= index_to_keycode(r_index);
                                    r_newkey  <= 1'b1;
                                end
                            end else begin
                                r_db_cnt <= w_db_inc;
                            end
                        end else begin
                            r_db_cnt <= '0;
                            r_state  <= ST_SCAN;
                            r_col    <= w_col_next;
                            r_col_n  <= {r_col_n[3:0], r_col_n[4]};
                        end
                    end
                end
                ST_HELD: begin
                    if (w_tick && !w_same) begin
                        r_db_cnt <= '0;
                        r_state  <= ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_tick) begin
                        if (!w_row_sync[r_row]) begin
                            r_db_cnt <= '0;
                            r_state  <= ST_HELD;
                        end else if (w_all_high) begin
                            if (w_db_last) begin
                                r_db_cnt   <= '0;
                                r_key_held <= 1'b0;
                                r_state    <= ST_SCAN;
                            end else begin
                                r_db_cnt <= w_db_inc;
                            end
                        end else begin
                            r_db_cnt <= '0;
                        end
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign col_n    = r_col_n;
    assign keycode  = r_keycode;
    assign newkey   = r_newkey;
    assign key_held = r_key_held;

endmodule
